prog_timer: RTL and testbench

Parametrised, software-loadable interval timer. Successor to the fixed-count single-shot timer: adds runtime period, one-shot/periodic mode, a clock prescaler, abort, restart and status outputs. Sits beside the control FSMs and produces single-cycle timeout/tick pulses for them.

---
 rtl/prog_timer_pkg.sv | 14 +
 rtl/prog_timer_if.sv | 41 ++++
 rtl/prog_timer_prescaler.sv | 36 +++
 rtl/prog_timer.sv | 144 ++++++++++++++
 tb/tb_prog_timer.sv | 319 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/prog_timer_pkg.sv
// timer_pkg: shared encodings for the programmable interval timer.
//   - FSM state encoding (IDLE / COUNT)
//   - mode constants (one-shot / periodic)
package timer_pkg;

  typedef enum logic [1:0] {
    TIMR_IDLE_S  = 2'd0,
    TIMR_COUNT_S = 2'd1
  } timr_state_e;

  localparam logic TIMR_MODE_ONESHOT  = 1'b0;
  localparam logic TIMR_MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/prog_timer_if.sv
// prog_timer_if: control/status bundle between a controller and prog_timer.
//   master : drives CLR, START, STOP, MODE, LOAD_VAL, PRESCALE (+IRQ_ACK)
//   slave  : drives PULSE, BUSY, COUNT (+IRQ)
// Optional: TIMER_STICKY_IRQ_EN adds the IRQ / IRQ_ACK pair.
interface prog_timer_if #(
  parameter int WIDTH = 21,
  parameter int PS_W  = 8
);
  logic             CLR;
  logic             START;
  logic             STOP;
  logic             MODE;
  logic [WIDTH-1:0] LOAD_VAL;
  logic [PS_W-1:0]  PRESCALE;
  logic             PULSE;
  logic             BUSY;
  logic [WIDTH-1:0] COUNT;
`ifdef TIMER_STICKY_IRQ_EN
  logic             IRQ;
  logic             IRQ_ACK;
`endif

  modport master (
    output CLR, START, STOP, MODE, LOAD_VAL, PRESCALE,
`ifdef TIMER_STICKY_IRQ_EN
    output IRQ_ACK,
    input  IRQ,
`endif
    input  PULSE, BUSY, COUNT
  );

  modport slave (
    input  CLR, START, STOP, MODE, LOAD_VAL, PRESCALE,
`ifdef TIMER_STICKY_IRQ_EN
    input  IRQ_ACK,
    output IRQ,
`endif
    output PULSE, BUSY, COUNT
  );

endinterface

// File: rtl/prog_timer_prescaler.sv
// timer_prescaler: clock divider producing a one-cycle tick enable.
//   CLK, RST_N : clock, async active-low reset
//   CLR        : synchronous clear (highest sync priority)
//   SYNC_RST   : restart the divider from 0
//   EN         : count enable (only while the timer is counting)
//   DIV        : tick every DIV+1 enabled clocks
//   TICK       : high in the cycle the divider sits at DIV
module timer_prescaler #(
  parameter int PS_W = 8
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            CLR,
  input  logic            EN,
  input  logic            SYNC_RST,
  input  logic [PS_W-1:0] DIV,
  output logic            TICK
);

  logic [PS_W-1:0] ps_cnt_q, ps_cnt_d;

  assign TICK = EN && (ps_cnt_q == DIV);

  always_comb begin
    ps_cnt_d = ps_cnt_q;
    if (CLR || SYNC_RST)  ps_cnt_d = '0;
    else if (TICK)        ps_cnt_d = '0;
    else if (EN)          ps_cnt_d = ps_cnt_q + PS_W'(1);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) ps_cnt_q <= '0;
    else        ps_cnt_q <= ps_cnt_d;
  end

endmodule

// File: rtl/prog_timer.sv
// prog_timer: software-loadable interval timer, one-shot or periodic,
// with clock prescaler, abort (STOP) and restart (START while counting).
//   CLK, RST_N : clock, async active-low reset
//   bus        : prog_timer_if.slave (CLR/START/STOP/MODE/LOAD_VAL/PRESCALE
//                in; PULSE/BUSY/COUNT out)
// Optional: TIMER_STICKY_IRQ_EN adds a sticky IRQ flag cleared by IRQ_ACK.
// Terminal pulse lands N*(P+1) edges after the START edge (N=period, P=prescale).
module prog_timer
  import timer_pkg::*;
#(
  parameter int WIDTH = 21,
  parameter int PS_W  = 8
) (
  input  logic          CLK,
  input  logic          RST_N,
  prog_timer_if.slave   bus
);

  timr_state_e      state_q, state_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [PS_W-1:0]  ps_q, ps_d;
  logic             mode_q, mode_d;
  logic             pulse_q, pulse_d;
  logic             tick;
  logic             counting;

  assign counting = (state_q == TIMR_COUNT_S);

  // START/STOP both restart the divider so every run starts on a clean phase.
  timer_prescaler #(.PS_W(PS_W)) u_ps (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .CLR      (bus.CLR),
    .EN       (counting),
    .SYNC_RST (bus.START | bus.STOP),
    .DIV      (ps_q),
    .TICK     (tick)
  );

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= TIMR_IDLE_S;
    else        state_q <= state_d;
  end

  // Datapath registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      period_q <= '0;
      cnt_q    <= '0;
      ps_q     <= '0;
      mode_q   <= 1'b0;
      pulse_q  <= 1'b0;
    end else begin
      period_q <= period_d;
      cnt_q    <= cnt_d;
      ps_q     <= ps_d;
      mode_q   <= mode_d;
      pulse_q  <= pulse_d;
    end
  end

  // Next-state / datapath logic. Priority: CLR, STOP, START, tick.
  always_comb begin
    state_d  = state_q;
    period_d = period_q;
    cnt_d    = cnt_q;
    ps_d     = ps_q;
    mode_d   = mode_q;
    pulse_d  = 1'b0;
    if (bus.CLR) begin
      state_d  = TIMR_IDLE_S;
      period_d = '0;
      cnt_d    = '0;
      ps_d     = '0;
      mode_d   = 1'b0;
    end else begin
      case (state_q)
        TIMR_IDLE_S: begin
          if (!bus.STOP && bus.START) begin
            // A zero period would never reach a terminal count; run it as 1.
            period_d = (bus.LOAD_VAL == '0) ? WIDTH'(1) : bus.LOAD_VAL;
            mode_d   = bus.MODE;
            ps_d     = bus.PRESCALE;
            cnt_d    = '0;
            state_d  = TIMR_COUNT_S;
          end
        end
        TIMR_COUNT_S: begin
          if (bus.STOP) begin
            state_d = TIMR_IDLE_S;
            cnt_d   = '0;
          end else if (bus.START) begin
            period_d = (bus.LOAD_VAL == '0) ? WIDTH'(1) : bus.LOAD_VAL;
            mode_d   = bus.MODE;
            ps_d     = bus.PRESCALE;
            cnt_d    = '0;
          end else if (tick) begin
            if (cnt_q == period_q - WIDTH'(1)) begin
              pulse_d = 1'b1;
              cnt_d   = '0;
              state_d = (mode_q == TIMR_MODE_PERIODIC) ? TIMR_COUNT_S
                                                       : TIMR_IDLE_S;
            end else begin
              cnt_d = cnt_q + WIDTH'(1);
            end
          end
        end
        default: begin
          state_d = TIMR_IDLE_S;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs
  always_comb begin
    bus.PULSE = pulse_q;
    bus.BUSY  = counting;
    bus.COUNT = cnt_q;
  end

`ifdef TIMER_STICKY_IRQ_EN
  logic irq_q, irq_d;

  // Set wins over ack so a pulse coinciding with an ack is never lost.
  always_comb begin
    irq_d = irq_q;
    if (bus.CLR)          irq_d = 1'b0;
    else if (pulse_d)     irq_d = 1'b1;
    else if (bus.IRQ_ACK) irq_d = 1'b0;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) irq_q <= 1'b0;
    else        irq_q <= irq_d;
  end

  assign bus.IRQ = irq_q;
`endif

endmodule

// File: tb/tb_prog_timer.sv
module tb_prog_timer;
  import timer_pkg::*;

  localparam int WIDTH = 21;
  localparam int PS_W  = 8;

  logic CLK = 1'b0;
  logic RST_N;
  int   tests = 0;
  int   fails = 0;

  prog_timer_if #(.WIDTH(WIDTH), .PS_W(PS_W)) bus ();

  prog_timer #(.WIDTH(WIDTH), .PS_W(PS_W)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  // Advance one rising edge; outputs are then sampled 1ns after the edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    bus.CLR      = 1'b0;
    bus.START    = 1'b0;
    bus.STOP     = 1'b0;
    bus.MODE     = TIMR_MODE_ONESHOT;
    bus.LOAD_VAL = '0;
    bus.PRESCALE = '0;
`ifdef TIMER_STICKY_IRQ_EN
    bus.IRQ_ACK  = 1'b0;
`endif
  endtask

  task automatic start(input logic [WIDTH-1:0] lv, input logic md, input logic [PS_W-1:0] ps);
    bus.LOAD_VAL = lv;
    bus.MODE     = md;
    bus.PRESCALE = ps;
    bus.START    = 1'b1;
    step();
    bus.START    = 1'b0;
  endtask

  task automatic test_reset();
    logic [WIDTH+1:0] exp_v;
    idle_inputs();
    RST_N = 1'b0;
    step();
    step();
    exp_v = '0;
    tests++;
    if ({bus.PULSE, bus.BUSY, bus.COUNT} !== exp_v) begin
      fails++;
      $display("FAIL reset_hold: got %h want %h", {bus.PULSE, bus.BUSY, bus.COUNT}, exp_v);
    end
    RST_N = 1'b1;
    step();
    tests++;
    if ({bus.PULSE, bus.BUSY, bus.COUNT} !== exp_v) begin
      fails++;
      $display("FAIL reset_release: got %h want %h", {bus.PULSE, bus.BUSY, bus.COUNT}, exp_v);
    end
  endtask

  // LOAD=5, PRESCALE=0, one-shot: pulse only after edge k+5.
  task automatic test_oneshot();
    logic [WIDTH+1:0] exp_v;
    start(21'd5, 1'b0, 8'd0);
    exp_v = {1'b0, 1'b1, 21'd0};
    tests++;
    if ({bus.PULSE, bus.BUSY, bus.COUNT} !== exp_v) begin
      fails++;
      $display("FAIL oneshot_start: got %h want %h", {bus.PULSE, bus.BUSY, bus.COUNT}, exp_v);
    end
    for (int i = 1; i <= 55; i++) begin
      step();
      exp_v = {(i == 5), (i < 5), (i < 5) ? WIDTH'(i) : WIDTH'(0)};
      tests++;
      if ({bus.PULSE, bus.BUSY, bus.COUNT} !== exp_v) begin
        fails++;
        $display("FAIL oneshot cyc %0d: got %h want %h", i, {bus.PULSE, bus.BUSY, bus.COUNT}, exp_v);
      end
    end
  endtask

  // LOAD=3, PRESCALE=2, periodic: pulses after edges 9,18,27; COUNT 0,1,2.
  task automatic test_periodic_prescale();
    logic [WIDTH+1:0] exp_v;
    start(21'd3, 1'b1, 8'd2);
    for (int i = 1; i <= 30; i++) begin
      step();
      exp_v = {(i % 9 == 0), 1'b1, WIDTH'((i / 3) % 3)};
      tests++;
      if ({bus.PULSE, bus.BUSY, bus.COUNT} !== exp_v) begin
        fails++;
        $display("FAIL periodic_ps cyc %0d: got %h want %h", i, {bus.PULSE, bus.BUSY, bus.COUNT}, exp_v);
      end
    end
    bus.STOP = 1'b1;
    step();
    bus.STOP = 1'b0;
    exp_v = '0;
    tests++;
    if ({bus.PULSE, bus.BUSY, bus.COUNT} !== exp_v) begin
      fails++;
      $display("FAIL periodic_stop: got %h want %h", {bus.PULSE, bus.BUSY, bus.COUNT}, exp_v);
    end
  endtask

  task automatic test_edge_values();
    logic [WIDTH+1:0] exp_v;
    // LOAD=0 runs as 1
    start(21'd0, 1'b0, 8'd0);
    for (int i = 1; i <= 4; i++) begin
      step();
      exp_v = {(i == 1), 1'b0, 21'd0};
      tests++;
      if ({bus.PULSE, bus.BUSY, bus.COUNT} !== exp_v) begin
        fails++;
        $display("FAIL load0 cyc %0d: got %h want %h", i, {bus.PULSE, bus.BUSY, bus.COUNT}, exp_v);
      end
    end
    // LOAD=1 periodic: pulse every cycle
    start(21'd1, 1'b1, 8'd0);
    for (int i = 1; i <= 8; i++) begin
      step();
      exp_v = {1'b1, 1'b1, 21'd0};
      tests++;
      if ({bus.PULSE, bus.BUSY, bus.COUNT} !== exp_v) begin
        fails++;
        $display("FAIL load1_periodic cyc %0d: got %h want %h", i, {bus.PULSE, bus.BUSY, bus.COUNT}, exp_v);
      end
    end
    bus.STOP = 1'b1;
    step();
    bus.STOP = 1'b0;
    // Maximum period counts up normally
    start(21'h1FFFFF, 1'b0, 8'd0);
    for (int i = 1; i <= 6; i++) begin
      step();
      exp_v = {1'b0, 1'b1, WIDTH'(i)};
      tests++;
      if ({bus.PULSE, bus.BUSY, bus.COUNT} !== exp_v) begin
        fails++;
        $display("FAIL loadmax cyc %0d: got %h want %h", i, {bus.PULSE, bus.BUSY, bus.COUNT}, exp_v);
      end
    end
    bus.STOP = 1'b1;
    step();
    bus.STOP = 1'b0;
  endtask

  task automatic test_collisions();
    logic [WIDTH+1:0] exp_v;
    // STOP on the terminal cycle suppresses the pulse
    start(21'd4, 1'b1, 8'd0);
    step(); step(); step();
    bus.STOP = 1'b1;
    step();
    bus.STOP = 1'b0;
    exp_v = '0;
    tests++;
    if ({bus.PULSE, bus.BUSY, bus.COUNT} !== exp_v) begin
      fails++;
      $display("FAIL stop_terminal: got %h want %h", {bus.PULSE, bus.BUSY, bus.COUNT}, exp_v);
    end
    for (int i = 1; i <= 10; i++) begin
      step();
      tests++;
      if ({bus.PULSE, bus.BUSY, bus.COUNT} !== exp_v) begin
        fails++;
        $display("FAIL stop_after cyc %0d: got %h want %h", i, {bus.PULSE, bus.BUSY, bus.COUNT}, exp_v);
      end
    end
    // START on the terminal cycle restarts with LOAD=4, no pulse
    start(21'd3, 1'b0, 8'd0);
    step(); step();
    start(21'd4, 1'b0, 8'd0);
    exp_v = {1'b0, 1'b1, 21'd0};
    tests++;
    if ({bus.PULSE, bus.BUSY, bus.COUNT} !== exp_v) begin
      fails++;
      $display("FAIL start_terminal: got %h want %h", {bus.PULSE, bus.BUSY, bus.COUNT}, exp_v);
    end
    for (int i = 1; i <= 6; i++) begin
      step();
      exp_v = {(i == 4), (i < 4), (i < 4) ? WIDTH'(i) : WIDTH'(0)};
      tests++;
      if ({bus.PULSE, bus.BUSY, bus.COUNT} !== exp_v) begin
        fails++;
        $display("FAIL restart cyc %0d: got %h want %h", i, {bus.PULSE, bus.BUSY, bus.COUNT}, exp_v);
      end
    end
    // Config changes mid-count are ignored
    start(21'd6, 1'b0, 8'd0);
    bus.LOAD_VAL = 21'd2;
    bus.MODE     = 1'b1;
    bus.PRESCALE = 8'd3;
    for (int i = 1; i <= 10; i++) begin
      step();
      exp_v = {(i == 6), (i < 6), (i < 6) ? WIDTH'(i) : WIDTH'(0)};
      tests++;
      if ({bus.PULSE, bus.BUSY, bus.COUNT} !== exp_v) begin
        fails++;
        $display("FAIL cfg_change cyc %0d: got %h want %h", i, {bus.PULSE, bus.BUSY, bus.COUNT}, exp_v);
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset_clear();
    logic [WIDTH+1:0] exp_v;
    exp_v = '0;
    // Async reset mid-count
    start(21'd5, 1'b1, 8'd0);
    step(); step();
    RST_N = 1'b0;
    #1;
    tests++;
    if ({bus.PULSE, bus.BUSY, bus.COUNT} !== exp_v) begin
      fails++;
      $display("FAIL async_rst: got %h want %h", {bus.PULSE, bus.BUSY, bus.COUNT}, exp_v);
    end
    step();
    RST_N = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      step();
      tests++;
      if ({bus.PULSE, bus.BUSY, bus.COUNT} !== exp_v) begin
        fails++;
        $display("FAIL post_rst cyc %0d: got %h want %h", i, {bus.PULSE, bus.BUSY, bus.COUNT}, exp_v);
      end
    end
    // Synchronous clear mid-count
    start(21'd5, 1'b1, 8'd0);
    step(); step();
    bus.CLR = 1'b1;
    step();
    bus.CLR = 1'b0;
    tests++;
    if ({bus.PULSE, bus.BUSY, bus.COUNT} !== exp_v) begin
      fails++;
      $display("FAIL clr: got %h want %h", {bus.PULSE, bus.BUSY, bus.COUNT}, exp_v);
    end
    for (int i = 1; i <= 100; i++) begin
      step();
      tests++;
      if ({bus.PULSE, bus.BUSY, bus.COUNT} !== exp_v) begin
        fails++;
        $display("FAIL post_clr cyc %0d: got %h want %h", i, {bus.PULSE, bus.BUSY, bus.COUNT}, exp_v);
      end
    end
  endtask

`ifdef TIMER_STICKY_IRQ_EN
  task automatic test_irq();
    logic [1:0] exp_v;
    bus.CLR = 1'b1;
    step();
    bus.CLR = 1'b0;
    start(21'd2, 1'b1, 8'd0);
    // {PULSE, IRQ} after edges k+1..k+6; ack held across edges k+4, k+5
    for (int i = 1; i <= 6; i++) begin
      bus.IRQ_ACK = (i == 4 || i == 5);
      step();
      case (i)
        1:       exp_v = 2'b00;
        2:       exp_v = 2'b11;
        3:       exp_v = 2'b01;
        4:       exp_v = 2'b11;
        5:       exp_v = 2'b00;
        default: exp_v = 2'b11;
      endcase
      tests++;
      if ({bus.PULSE, bus.IRQ} !== exp_v) begin
        fails++;
        $display("FAIL irq cyc %0d: got %b want %b", i, {bus.PULSE, bus.IRQ}, exp_v);
      end
    end
    bus.IRQ_ACK = 1'b0;
    bus.STOP = 1'b1;
    step();
    bus.STOP = 1'b0;
    tests++;
    if (bus.IRQ !== 1'b1) begin
      fails++;
      $display("FAIL irq_sticky_after_stop: got %b want 1", bus.IRQ);
    end
    bus.CLR = 1'b1;
    step();
    bus.CLR = 1'b0;
    tests++;
    if (bus.IRQ !== 1'b0) begin
      fails++;
      $display("FAIL irq_clr: got %b want 0", bus.IRQ);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_oneshot();
    test_periodic_prescale();
    test_edge_values();
    test_collisions();
    test_reset_clear();
`ifdef TIMER_STICKY_IRQ_EN
    test_irq();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
